// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache memory port: request sources,
// the downstream request payload and the per-TID bookkeeping entry.
package wt_cache_pkg;

    localparam int MemAddrWidth    = 64;
    localparam int MemDataWidth    = 64;
    localparam int MemBeWidth      = MemDataWidth / 8;
    localparam int MemLineWidth    = 128;
    localparam int MemUpTidWidth   = 2;
    localparam int MemTidWidth     = 3;
    localparam int MemMaxOutStores = 7;
    localparam int NumSrc          = 3;

    // Reads always fetch a full cache line, so their size is log2 of the line bytes.
    localparam logic [2:0] LineSize = 3'($clog2(MemLineWidth / 8));

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        DREAD  = 2'd1,
        STORE  = 2'd2
    } mem_src_e;

    typedef struct packed {
        mem_src_e                  src;
        logic [MemAddrWidth-1:0]   addr;
        logic [MemDataWidth-1:0]   wdata;
        logic [MemBeWidth-1:0]     be;
        logic [2:0]                size;
        logic [MemTidWidth-1:0]    tid;
    } mem_req_t;

    typedef struct packed {
        logic                      valid;
        mem_src_e                  src;
        logic [MemUpTidWidth-1:0]  up_tid;
    } tid_entry_t;

    function automatic logic [NumSrc-1:0] src_onehot(input mem_src_e s);
        return 3'b001 << s;
    endfunction

endpackage

// File: rtl/mem_tid_pool.sv
// Pool of downstream transaction IDs: a free bitvector with a lowest-free
// priority encoder. Allocation only sees IDs that were free at the last edge.
module mem_tid_pool #(
    parameter int TidWidth = 3,
    parameter int NumTids  = 2**TidWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_i,
    input  logic                free_i,
    input  logic [TidWidth-1:0] free_tid_i,
    output logic [TidWidth-1:0] alloc_tid_o,
    output logic                full_o
);

    logic [NumTids-1:0] free_q;
    logic [NumTids-1:0] free_d;

    always_comb begin
        alloc_tid_o = '0;
        for (int i = NumTids - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc_tid_o = TidWidth'(i);
            end
        end
    end

    assign full_o = ~|free_q;

    // The freed ID and the allocated ID are never the same: one is taken, the other busy.
    always_comb begin
        free_d = free_q;
        if (alloc_i && !full_o) begin
            free_d[alloc_tid_o] = 1'b0;
        end
        if (free_i) begin
            free_d[free_tid_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the memory request port between I$ refills, D$ reads
// and D$ write-through stores, with TID remapping and an outstanding-store cap.
module wt_mem_req_arbiter
    import wt_cache_pkg::*;
#(
    parameter int AddrWidth    = MemAddrWidth,
    parameter int DataWidth    = MemDataWidth,
    parameter int BeWidth      = DataWidth / 8,
    parameter int LineWidth    = MemLineWidth,
    parameter int UpTidWidth   = MemUpTidWidth,
    parameter int TidWidth     = MemTidWidth,
    parameter int MaxOutStores = MemMaxOutStores
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [2:0]                  req_valid_i,
    output logic [2:0]                  req_ready_o,
    input  logic [3*AddrWidth-1:0]      req_addr_i,
    input  logic [3*UpTidWidth-1:0]     req_tid_i,
    input  logic [DataWidth-1:0]        st_wdata_i,
    input  logic [BeWidth-1:0]          st_be_i,
    input  logic [2:0]                  st_size_i,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [1:0]                  mem_req_type_o,
    output logic [AddrWidth-1:0]        mem_req_addr_o,
    output logic [DataWidth-1:0]        mem_req_wdata_o,
    output logic [BeWidth-1:0]          mem_req_be_o,
    output logic [2:0]                  mem_req_size_o,
    output logic [TidWidth-1:0]         mem_req_tid_o,
    input  logic                        mem_rsp_valid_i,
    input  logic [TidWidth-1:0]         mem_rsp_tid_i,
    input  logic [LineWidth-1:0]        mem_rsp_rdata_i,
    input  logic                        mem_rsp_err_i,
    output logic [2:0]                  rsp_valid_o,
    output logic [UpTidWidth-1:0]       rsp_tid_o,
    output logic [LineWidth-1:0]        rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        spurious_rsp_o,
    output logic                        stores_empty_o
);

    localparam int NumTids  = 2**TidWidth;
    localparam int CntWidth = $clog2(MaxOutStores + 1);

    mem_req_t                   out_q, out_d;
    logic                       out_valid_q, out_valid_d;
    tid_entry_t [NumTids-1:0]   tbl_q, tbl_d;
    logic [CntWidth-1:0]        store_cnt_q, store_cnt_d;
    mem_src_e                   rr_ptr_q, rr_ptr_d;

    logic [2:0]                 rsp_valid_q, rsp_valid_d;
    logic [UpTidWidth-1:0]      rsp_tid_q, rsp_tid_d;
    logic [LineWidth-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;
    logic                       spurious_q, spurious_d;

    logic                       can_load;
    logic                       store_ok;
    logic                       pool_full;
    logic [TidWidth-1:0]        alloc_tid;
    logic [2:0]                 eligible;
    logic [2:0]                 grant;
    logic [1:0]                 rr_idx;
    mem_src_e                   gnt_src;
    mem_req_t                   new_req;
    tid_entry_t                 hit_entry;
    logic                       rsp_hit;
    logic                       store_inc;
    logic                       store_dec;

    assign can_load = !out_valid_q || mem_req_ready_i;
    assign store_ok = store_cnt_q < CntWidth'(MaxOutStores);
    assign eligible = req_valid_i & {3{can_load && !pool_full}} & {store_ok, 2'b11};

    // Scan from the pointer backwards so the source closest to the pointer wins last.
    always_comb begin
        grant   = '0;
        gnt_src = IFETCH;
        rr_idx  = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            rr_idx = 2'((int'(rr_ptr_q) + i) % NumSrc);
            if (eligible[rr_idx]) begin
                grant         = '0;
                grant[rr_idx] = 1'b1;
                gnt_src       = mem_src_e'(rr_idx);
            end
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        new_req        = '0;
        new_req.src    = gnt_src;
        new_req.tid    = alloc_tid;
        new_req.addr   = req_addr_i[int'(gnt_src)*AddrWidth +: AddrWidth];
        new_req.size   = LineSize;
        if (gnt_src == STORE) begin
            new_req.wdata = st_wdata_i;
            new_req.be    = st_be_i;
            new_req.size  = st_size_i;
        end
    end

    assign hit_entry = tbl_q[mem_rsp_tid_i];
    assign rsp_hit   = mem_rsp_valid_i && hit_entry.valid;
    assign store_inc = (|grant) && (gnt_src == STORE);
    assign store_dec = rsp_hit && (hit_entry.src == STORE);

    mem_tid_pool #(
        .TidWidth (TidWidth),
        .NumTids  (NumTids)
    ) u_tid_pool (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_i     (|grant),
        .free_i      (rsp_hit),
        .free_tid_i  (mem_rsp_tid_i),
        .alloc_tid_o (alloc_tid),
        .full_o      (pool_full)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        tbl_d       = tbl_q;
        store_cnt_d = store_cnt_q;
        rr_ptr_d    = rr_ptr_q;

        if (|grant) begin
            out_valid_d = 1'b1;
            out_d       = new_req;
            rr_ptr_d    = (gnt_src == STORE) ? IFETCH : mem_src_e'(gnt_src + 2'd1);
            tbl_d[alloc_tid].valid  = 1'b1;
            tbl_d[alloc_tid].src    = gnt_src;
            tbl_d[alloc_tid].up_tid = req_tid_i[int'(gnt_src)*UpTidWidth +: UpTidWidth];
        end else if (mem_req_ready_i) begin
            out_valid_d = 1'b0;
            out_d       = '0;
        end

        if (rsp_hit) begin
            tbl_d[mem_rsp_tid_i] = '0;
        end

        case ({store_inc, store_dec})
            2'b10:   store_cnt_d = store_cnt_q + CntWidth'(1);
            2'b01:   store_cnt_d = store_cnt_q - CntWidth'(1);
            default: store_cnt_d = store_cnt_q;
        endcase
    end

    // Store acks carry no line data, so their read data is forced to zero.
    always_comb begin
        rsp_valid_d = '0;
        rsp_tid_d   = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        spurious_d  = mem_rsp_valid_i && !hit_entry.valid;
        if (rsp_hit) begin
            rsp_valid_d = src_onehot(hit_entry.src);
            rsp_tid_d   = hit_entry.up_tid;
            rsp_err_d   = mem_rsp_err_i;
            if (hit_entry.src != STORE) begin
                rsp_rdata_d = mem_rsp_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            tbl_q       <= '0;
            store_cnt_q <= '0;
            rr_ptr_q    <= IFETCH;
            rsp_valid_q <= '0;
            rsp_tid_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            tbl_q       <= tbl_d;
            store_cnt_q <= store_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tid_q   <= rsp_tid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            spurious_q  <= spurious_d;
        end
    end

    assign mem_req_valid_o = out_valid_q;
    assign mem_req_type_o  = out_q.src;
    assign mem_req_addr_o  = out_q.addr;
    assign mem_req_wdata_o = out_q.wdata;
    assign mem_req_be_o    = out_q.be;
    assign mem_req_size_o  = out_q.size;
    assign mem_req_tid_o   = out_q.tid;

    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_tid_o       = rsp_tid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_err_o       = rsp_err_q;
    assign spurious_rsp_o  = spurious_q;

    // A store sitting in the output register is already counted in store_cnt_q.
    assign stores_empty_o  = (store_cnt_q == '0) && !(out_valid_q && out_q.src == STORE);

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed bench for wt_mem_req_arbiter: round-robin order, TID pool exhaustion,
// store cap, backpressure, spurious responses and mid-operation reset.
module tb_wt_mem_req_arbiter;

    logic           clk_i;
    logic           rst_i;
    logic [2:0]     req_valid_i;
    logic [2:0]     req_ready_o;
    logic [191:0]   req_addr_i;
    logic [5:0]     req_tid_i;
    logic [63:0]    st_wdata_i;
    logic [7:0]     st_be_i;
    logic [2:0]     st_size_i;
    logic           mem_req_valid_o;
    logic           mem_req_ready_i;
    logic [1:0]     mem_req_type_o;
    logic [63:0]    mem_req_addr_o;
    logic [63:0]    mem_req_wdata_o;
    logic [7:0]     mem_req_be_o;
    logic [2:0]     mem_req_size_o;
    logic [2:0]     mem_req_tid_o;
    logic           mem_rsp_valid_i;
    logic [2:0]     mem_rsp_tid_i;
    logic [127:0]   mem_rsp_rdata_i;
    logic           mem_rsp_err_i;
    logic [2:0]     rsp_valid_o;
    logic [1:0]     rsp_tid_o;
    logic [127:0]   rsp_rdata_o;
    logic           rsp_err_o;
    logic           spurious_rsp_o;
    logic           stores_empty_o;

    int checkCount;
    int failCount;

    localparam logic [127:0] LinePattern = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [63:0]  StoreData   = 64'hdead_beef_0000_0001;

    wt_mem_req_arbiter dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_tid_i       (req_tid_i),
        .st_wdata_i      (st_wdata_i),
        .st_be_i         (st_be_i),
        .st_size_i       (st_size_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_type_o  (mem_req_type_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_be_o    (mem_req_be_o),
        .mem_req_size_o  (mem_req_size_o),
        .mem_req_tid_o   (mem_req_tid_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_tid_i   (mem_rsp_tid_i),
        .mem_rsp_rdata_i (mem_rsp_rdata_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_tid_o       (rsp_tid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .spurious_rsp_o  (spurious_rsp_o),
        .stores_empty_o  (stores_empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic memReady,
                                 input logic rspValid, input logic [2:0] rspTid);
        req_valid_i     = valid;
        mem_req_ready_i = memReady;
        mem_rsp_valid_i = rspValid;
        mem_rsp_tid_i   = rspTid;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount      = 0;
        failCount       = 0;
        rst_i           = 1'b1;
        req_valid_i     = '0;
        req_addr_i      = '0;
        req_tid_i       = '0;
        st_wdata_i      = '0;
        st_be_i         = '0;
        st_size_i       = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_tid_i   = '0;
        mem_rsp_rdata_i = LinePattern;
        mem_rsp_err_i   = 1'b0;

        // Reset values
        tick();
        tick();
        checkOutput("rst_mem_valid", mem_req_valid_o, 0);
        checkOutput("rst_stores_empty", stores_empty_o, 1);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_spurious", spurious_rsp_o, 0);
        checkOutput("rst_req_ready", req_ready_o, 0);
        rst_i = 1'b0;

        // Single IFETCH round trip
        $display("[TB] single ifetch");
        req_addr_i[63:0] = 64'h8000_0000;
        req_tid_i[1:0]   = 2'd1;
        applyStimulus(3'b001, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_ready", req_ready_o, 3'b001);
        tick();
        applyStimulus(3'b000, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_mem_valid", mem_req_valid_o, 1);
        checkOutput("t1_mem_tid", mem_req_tid_o, 0);
        checkOutput("t1_mem_type", mem_req_type_o, 0);
        checkOutput("t1_mem_addr", mem_req_addr_o, 64'h8000_0000);
        checkOutput("t1_mem_size", mem_req_size_o, 4);
        checkOutput("t1_mem_be", mem_req_be_o, 0);
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        tick();
        checkOutput("t1_mem_drained", mem_req_valid_o, 0);
        applyStimulus(3'b000, 1'b1, 1'b1, 3'd0);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t1_rsp_valid", rsp_valid_o, 3'b001);
        checkOutput("t1_rsp_tid", rsp_tid_o, 1);
        checkOutput("t1_rsp_rdata", rsp_rdata_o, LinePattern);
        checkOutput("t1_rsp_spurious", spurious_rsp_o, 0);
        tick();
        checkOutput("t1_rsp_cleared", rsp_valid_o, 0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Round-robin with all sources valid until the pool runs dry
        $display("[TB] round robin");
        req_addr_i = {64'h3000, 64'h2000, 64'h1000};
        req_tid_i  = {2'd2, 2'd1, 2'd0};
        st_wdata_i = StoreData;
        st_be_i    = 8'hff;
        st_size_i  = 3'd3;
        applyStimulus(3'b111, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t2_rr_ready", req_ready_o, 3'b001 << (k % 3));
            tick();
            checkOutput("t2_rr_tid", mem_req_tid_o, k);
            checkOutput("t2_rr_type", mem_req_type_o, k % 3);
            checkOutput("t2_rr_addr", mem_req_addr_o, 64'h1000 * ((k % 3) + 1));
            checkOutput("t2_rr_wdata", mem_req_wdata_o, (k % 3 == 2) ? StoreData : 64'h0);
        end
        checkOutput("t2_pool_full", req_ready_o, 0);
        checkOutput("t2_stores_busy", stores_empty_o, 0);
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        tick();
        checkOutput("t2_drained", mem_req_valid_o, 0);
        for (int t = 0; t < 8; t++) begin
            applyStimulus(3'b000, 1'b1, 1'b1, 3'(t));
            tick();
            checkOutput("t2_rsp_valid", rsp_valid_o, 3'b001 << (t % 3));
            checkOutput("t2_rsp_tid", rsp_tid_o, t % 3);
            checkOutput("t2_rsp_rdata", rsp_rdata_o, (t % 3 == 2) ? 128'h0 : LinePattern);
        end
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        tick();
        checkOutput("t2_stores_empty", stores_empty_o, 1);
        checkOutput("t2_rsp_idle", rsp_valid_o, 0);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Outstanding-store cap
        $display("[TB] store cap");
        applyStimulus(3'b100, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k < 7; k++) begin
            checkOutput("t3_store_ready", req_ready_o, 3'b100);
            tick();
            checkOutput("t3_store_tid", mem_req_tid_o, k);
        end
        applyStimulus(3'b110, 1'b1, 1'b0, 3'd0);
        checkOutput("t3_store_cap", req_ready_o, 3'b010);
        tick();
        checkOutput("t3_dread_tid", mem_req_tid_o, 7);
        checkOutput("t3_dread_type", mem_req_type_o, 1);
        applyStimulus(3'b100, 1'b1, 1'b1, 3'd0);
        checkOutput("t3_freed_not_yet", req_ready_o, 0);
        tick();
        applyStimulus(3'b100, 1'b1, 1'b0, 3'd0);
        checkOutput("t3_ack_valid", rsp_valid_o, 3'b100);
        checkOutput("t3_ack_tid", rsp_tid_o, 2);
        checkOutput("t3_ack_rdata", rsp_rdata_o, 0);
        checkOutput("t3_store_resume", req_ready_o, 3'b100);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t3_resume_tid", mem_req_tid_o, 0);
        checkOutput("t3_resume_type", mem_req_type_o, 2);

        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        // Downstream backpressure
        $display("[TB] backpressure");
        applyStimulus(3'b011, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_first_ready", req_ready_o, 3'b001);
        tick();
        for (int c = 0; c < 5; c++) begin
            checkOutput("t4_stall_ready", req_ready_o, 0);
            checkOutput("t4_stall_valid", mem_req_valid_o, 1);
            checkOutput("t4_stall_addr", mem_req_addr_o, 64'h1000);
            checkOutput("t4_stall_tid", mem_req_tid_o, 0);
            tick();
        end
        applyStimulus(3'b011, 1'b1, 1'b0, 3'd0);
        checkOutput("t4_ready_rise", req_ready_o, 3'b010);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t4_next_valid", mem_req_valid_o, 1);
        checkOutput("t4_next_tid", mem_req_tid_o, 1);
        checkOutput("t4_next_type", mem_req_type_o, 1);
        checkOutput("t4_next_addr", mem_req_addr_o, 64'h2000);
        tick();
        checkOutput("t4_idle", mem_req_valid_o, 0);

        // Spurious response, then a store grant coinciding with a store ack
        $display("[TB] spurious and store overlap");
        applyStimulus(3'b000, 1'b1, 1'b1, 3'd5);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t5_spurious", spurious_rsp_o, 1);
        checkOutput("t5_spurious_no_rsp", rsp_valid_o, 0);
        tick();
        checkOutput("t5_spurious_pulse", spurious_rsp_o, 0);
        applyStimulus(3'b100, 1'b1, 1'b0, 3'd0);
        checkOutput("t5_store_ready", req_ready_o, 3'b100);
        tick();
        checkOutput("t5_store_tid", mem_req_tid_o, 2);
        applyStimulus(3'b100, 1'b1, 1'b1, 3'd2);
        checkOutput("t5_overlap_ready", req_ready_o, 3'b100);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t5_overlap_tid", mem_req_tid_o, 3);
        checkOutput("t5_overlap_ack", rsp_valid_o, 3'b100);
        tick();
        checkOutput("t5_overlap_drained", mem_req_valid_o, 0);
        checkOutput("t5_cnt_unchanged", stores_empty_o, 0);
        applyStimulus(3'b000, 1'b1, 1'b1, 3'd3);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t5_last_ack", rsp_valid_o, 3'b100);
        checkOutput("t5_stores_empty", stores_empty_o, 1);

        // Reset with three transactions in flight
        $display("[TB] reset mid-operation");
        applyStimulus(3'b100, 1'b1, 1'b0, 3'd0);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t6_store_tid", mem_req_tid_o, 2);
        tick();
        checkOutput("t6_stores_busy", stores_empty_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("t6_rst_stores_empty", stores_empty_o, 1);
        checkOutput("t6_rst_mem_valid", mem_req_valid_o, 0);
        applyStimulus(3'b000, 1'b1, 1'b1, 3'd2);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t6_late_spurious", spurious_rsp_o, 1);
        checkOutput("t6_late_no_rsp", rsp_valid_o, 0);
        applyStimulus(3'b001, 1'b1, 1'b0, 3'd0);
        checkOutput("t6_pool_ready", req_ready_o, 3'b001);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0, 3'd0);
        checkOutput("t6_pool_free_tid", mem_req_tid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
